// File: rtl/bf2ii_feedback_ctrl.sv
// bf2ii_feedback_ctrl
//   Sequential companion to the radix-2^2 SDF butterfly-II datapath. Holds
//   the depth-D feedback delay line that returns the butterfly's toreg
//   outputs to its fromreg inputs, derives the per-sample s/t control bits
//   from a modulo-4D sample counter, and flags valid/primed/frame-end so the
//   stage can be chained behind its butterfly-I stage.
//
// Parameters
//   data_width  width of each real/imag sample word
//   log2_depth  log2 of the feedback delay D (D = 2**log2_depth, 0..10)
//
// Ports
//   clk         rising-edge clock for all state
//   rst         synchronous, active-high reset
//   in_valid    a sample pair is presented this cycle; state advances only then
//   sync        with in_valid, the current sample becomes index 0 of a frame
//   toreg_r/i   butterfly words to be delayed
//   fromreg_r/i words written D valid samples earlier (0 until primed)
//   s           butterfly select, counter bit [log2_depth]
//   t           trivial-twiddle control, counter bit [log2_depth+1]
//   primed      delay line holds D valid samples since reset/sync
//   out_valid   in_valid and primed
//   frame_last  in_valid on the last sample (4D-1) of a frame
module bf2ii_feedback_ctrl #(
   parameter int data_width = 13,
   parameter int log2_depth = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic                  sync,
   input  logic [data_width-1:0] toreg_r,
   input  logic [data_width-1:0] toreg_i,
   output logic [data_width-1:0] fromreg_r,
   output logic [data_width-1:0] fromreg_i,
   output logic                  s,
   output logic                  t,
   output logic                  primed,
   output logic                  out_valid,
   output logic                  frame_last
);

   localparam int DEPTH  = 1 << log2_depth;
   localparam int PTR_W  = (log2_depth > 0) ? log2_depth : 1;
   localparam int CNT_W  = log2_depth + 2;
   localparam int FILL_W = log2_depth + 1;

   logic [CNT_W-1:0]      cnt;
   logic [PTR_W-1:0]      ptr;
   logic [FILL_W-1:0]     fill;
   logic                  primed_q;
   logic [data_width-1:0] mem_r [DEPTH];
   logic [data_width-1:0] mem_i [DEPTH];

   logic [CNT_W-1:0]      cnt_n;
   logic [PTR_W-1:0]      ptr_n;
   logic [FILL_W-1:0]     fill_n;
   logic                  primed_n;
   logic [PTR_W-1:0]      wr_idx;
   logic                  sync_hit;
   logic                  primed_eff;

   // A sync sample restarts the frame at index 0, so it must see the reset
   // view of the control bits and an unprimed (masked) delay line even
   // though the registers still hold the previous frame's state.
   assign sync_hit   = in_valid & sync;
   assign primed_eff = primed_q & ~sync_hit;

   // Read path: purely combinational from the registers. The slot at ptr is
   // the oldest entry, written exactly D valid samples ago, and is read
   // before this cycle's write replaces it.
   always_comb begin
      fromreg_r  = '0;
      fromreg_i  = '0;
      if (primed_eff) begin
         fromreg_r = mem_r[ptr];
         fromreg_i = mem_i[ptr];
      end
      s          = cnt[log2_depth] & ~sync_hit;
      t          = cnt[log2_depth+1] & ~sync_hit;
      primed     = primed_eff;
      out_valid  = in_valid & primed_eff;
      frame_last = in_valid & ~sync & (&cnt);
   end

   // Next-state logic. The counter and pointer widths are exact powers of
   // two, so plain increments give the 4D and D wrap for free; only the D=1
   // case needs the pointer pinned at 0. fill saturates at D and primed is
   // sticky until the next reset or sync.
   always_comb begin
      cnt_n    = cnt;
      ptr_n    = ptr;
      fill_n   = fill;
      primed_n = primed_q;
      wr_idx   = ptr;
      if (sync_hit) begin
         wr_idx   = '0;
         cnt_n    = CNT_W'(1);
         ptr_n    = (DEPTH == 1) ? '0 : PTR_W'(1);
         fill_n   = FILL_W'(1);
         primed_n = (DEPTH == 1);
      end else if (in_valid) begin
         cnt_n = cnt + CNT_W'(1);
         ptr_n = (DEPTH == 1) ? '0 : ptr + PTR_W'(1);
         if (fill != FILL_W'(DEPTH)) begin
            fill_n = fill + FILL_W'(1);
         end
         primed_n = primed_q | (fill_n == FILL_W'(DEPTH));
      end
   end

   // Control state register. Reset wins over in_valid/sync in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt      <= '0;
         ptr      <= '0;
         fill     <= '0;
         primed_q <= 1'b0;
      end else if (in_valid) begin
         cnt      <= cnt_n;
         ptr      <= ptr_n;
         fill     <= fill_n;
         primed_q <= primed_n;
      end
   end

   // Delay-line storage. Cleared on reset so fromreg is well defined from
   // the first primed cycle; a sync leaves old contents in place because
   // they stay masked by primed until overwritten.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < DEPTH; k++) begin
            mem_r[k] <= '0;
            mem_i[k] <= '0;
         end
      end else if (in_valid) begin
         mem_r[wr_idx] <= toreg_r;
         mem_i[wr_idx] <= toreg_i;
      end
   end

endmodule
